// File: rtl/dtr_pkg.sv
// Shared types and constants for the DTR input/output controllers.
// The micro-cycle code runs 0..MC_LAST while a word executes; MC_IDLE means no word in flight.
package dtr_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REPLAY = 2'd1,
        FATAL  = 2'd2
    } state_t;

    typedef logic [1:0] mc_t;

    localparam mc_t MC_LAST = 2'd2;
    localparam mc_t MC_IDLE = 2'd3;

endpackage

// File: rtl/dtr_mc_ctr.sv
// Mod-3 micro-cycle counter with an idle code. A start or restart loads 0; after
// MC_LAST the counter parks at MC_IDLE unless a new start arrives on that same edge.
module dtr_mc_ctr
    import dtr_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_restart,
    output mc_t  o_mc
);

    mc_t r_mc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mc <= MC_IDLE;
        end else if (i_start || i_restart) begin
            r_mc <= 2'd0;
        end else if (r_mc == MC_LAST) begin
            r_mc <= MC_IDLE;
        end else if (r_mc != MC_IDLE) begin
            r_mc <= r_mc + 2'd1;
        end
    end

    assign o_mc = r_mc;

endmodule

// File: rtl/dtr_in_ctrl.sv
// DTR input-side controller: presents each accepted word for three micro-cycles and
// replays it once with substitution on a mismatch. Build option: DTR_ERR_CNT_EN adds err_cnt.
module dtr_in_ctrl
    import dtr_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             pi_valid,
    output logic             pi_rdy,
    input  logic             fail,
    output logic [WIDTH-1:0] inNew,
    output logic [1:0]       mc,
    output logic             save,
    output logic             rollBack,
    output logic             subst,
    output logic             fatal,
    output logic [CNT_W-1:0] err_cnt
);

    state_t           r_state;
    logic [WIDTH-1:0] r_cur;
    logic             r_save;
    logic             r_rollback;
    logic             r_subst;
    logic             r_fatal;

    mc_t  w_mc;
    logic w_end;
    logic w_fail_end;
    logic w_accept;
    logic w_restart;

    assign w_end      = (w_mc == MC_LAST);
    assign w_fail_end = w_end && fail;
    // A failing word blocks the back-to-back acceptance that mc==2 would otherwise allow.
    assign pi_rdy     = !rst && (r_state == RUN) && ((w_mc == MC_IDLE) || (w_end && !fail));
    assign w_accept   = pi_valid && pi_rdy;
    assign w_restart  = (r_state == RUN) && w_fail_end;

    dtr_mc_ctr u_mc_ctr (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (w_accept),
        .i_restart (w_restart),
        .o_mc      (w_mc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_cur      <= '0;
            r_save     <= 1'b0;
            r_rollback <= 1'b0;
            r_subst    <= 1'b0;
            r_fatal    <= 1'b0;
        end else begin
            r_save  <= 1'b0;
            r_subst <= 1'b0;
            if (w_accept) begin
                r_cur <= pi;
            end
            case (r_state)
                RUN: begin
                    if (w_fail_end) begin
                        r_state    <= REPLAY;
                        r_rollback <= 1'b1;
                    end else if (w_end) begin
                        r_save <= 1'b1;
                    end
                end
                REPLAY: begin
                    // Substitution applies only to the third copy of the replayed word.
                    r_subst <= (w_mc == 2'd1);
                    if (w_end) begin
                        r_rollback <= 1'b0;
                        if (fail) begin
                            r_state <= FATAL;
                            r_fatal <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_save  <= 1'b1;
                        end
                    end
                end
                FATAL: begin
                    r_fatal <= 1'b1;
                end
                default: begin
                    r_state <= FATAL;
                    r_fatal <= 1'b1;
                end
            endcase
        end
    end

`ifdef DTR_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_restart && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

    assign inNew    = r_cur;
    assign mc       = w_mc;
    assign save     = r_save;
    assign rollBack = r_rollback;
    assign subst    = r_subst;
    assign fatal    = r_fatal;

endmodule

// File: tb/tb_dtr_in_ctrl.sv
// Bench for dtr_in_ctrl: per-cycle vector table, an inNew scoreboard queue, and
// hand-written reset / saturation sequences. Honours DTR_ERR_CNT_EN for err_cnt expectations.
module tb_dtr_in_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] pi;
    logic             pi_valid;
    logic             pi_rdy;
    logic             fail;
    logic [WIDTH-1:0] inNew;
    logic [1:0]       mc;
    logic             save;
    logic             rollBack;
    logic             subst;
    logic             fatal;
    logic [CNT_W-1:0] err_cnt;

    dtr_in_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .pi       (pi),
        .pi_valid (pi_valid),
        .pi_rdy   (pi_rdy),
        .fail     (fail),
        .inNew    (inNew),
        .mc       (mc),
        .save     (save),
        .rollBack (rollBack),
        .subst    (subst),
        .fatal    (fatal),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] p;
        logic             f;
        logic [1:0]       e_mc;
        logic             e_sv;
        logic             e_rb;
        logic             e_sb;
        logic             e_rdy;
        logic             e_fat;
        int               e_err;
    } vec_t;

    localparam int NROWS = 39;
    vec_t tbl [NROWS];

    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] last_word;
    int n_pass;
    int n_total;

    function automatic vec_t mk(input logic v, input logic [WIDTH-1:0] p, input logic f,
                                input logic [1:0] e_mc, input logic e_sv, input logic e_rb,
                                input logic e_sb, input logic e_rdy, input logic e_fat,
                                input int e_err);
        vec_t r;
        r.v = v; r.p = p; r.f = f; r.e_mc = e_mc; r.e_sv = e_sv; r.e_rb = e_rb;
        r.e_sb = e_sb; r.e_rdy = e_rdy; r.e_fat = e_fat; r.e_err = e_err;
        return r;
    endfunction

    // Expected counter value after n replays.
    function automatic logic [CNT_W-1:0] err_exp(input int n);
`ifdef DTR_ERR_CNT_EN
        int max_v;
        max_v = (1 << CNT_W) - 1;
        return (n > max_v) ? CNT_W'(max_v) : CNT_W'(n);
`else
        return '0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cyc(input logic v, input logic [WIDTH-1:0] p, input logic f, input logic r);
        @(negedge clk);
        pi_valid = v;
        pi       = p;
        fail     = f;
        rst      = r;
        #1;
    endtask

    task automatic chk_idle_reset(input string name);
        chk({name, " mc"},       32'(mc),       32'(3));
        chk({name, " outs"},     32'({save, rollBack, subst, fatal}), 32'(0));
        chk({name, " inNew"},    32'(inNew),    32'(0));
        chk({name, " err_cnt"},  32'(err_cnt),  32'(0));
    endtask

    task automatic fault_word(input logic [WIDTH-1:0] w, input int n);
        cyc(1'b1, w, 1'b0, 1'b0);
        chk("sat accept rdy", 32'(pi_rdy), 32'(1));
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("sat replay rb", 32'({mc, rollBack}), 32'({2'd0, 1'b1}));
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("sat save", 32'({mc, save, inNew}), 32'({2'd3, 1'b1, w}));
        chk("sat err_cnt", 32'(err_cnt), 32'(err_exp(n)));
    endtask

    initial begin
        vec_t r;
        n_pass = 0;
        n_total = 0;
        last_word = '0;

        //          v     p      f    mc   sv   rb   sb  rdy  fat err
        tbl[0]  = mk(1, 4'hA, 0, 2'd3, 0, 0, 0, 1, 0, 0);
        tbl[1]  = mk(0, 4'h0, 1, 2'd0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 4'h0, 0, 2'd1, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 4'h0, 0, 2'd2, 0, 0, 0, 1, 0, 0);
        tbl[4]  = mk(0, 4'h0, 0, 2'd3, 1, 0, 0, 1, 0, 0);
        tbl[5]  = mk(0, 4'h0, 1, 2'd3, 0, 0, 0, 1, 0, 0);
        tbl[6]  = mk(1, 4'h1, 0, 2'd3, 0, 0, 0, 1, 0, 0);
        tbl[7]  = mk(1, 4'h2, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 4'h2, 0, 2'd1, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 4'h2, 0, 2'd2, 0, 0, 0, 1, 0, 0);
        tbl[10] = mk(1, 4'h3, 0, 2'd0, 1, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 4'h3, 0, 2'd1, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 4'h3, 0, 2'd2, 0, 0, 0, 1, 0, 0);
        tbl[13] = mk(0, 4'h0, 0, 2'd0, 1, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 4'h0, 0, 2'd1, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 4'h0, 0, 2'd2, 0, 0, 0, 1, 0, 0);
        tbl[16] = mk(0, 4'h0, 0, 2'd3, 1, 0, 0, 1, 0, 0);
        tbl[17] = mk(1, 4'h5, 0, 2'd3, 0, 0, 0, 1, 0, 0);
        tbl[18] = mk(1, 4'h7, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        tbl[19] = mk(1, 4'h7, 0, 2'd1, 0, 0, 0, 0, 0, 0);
        tbl[20] = mk(1, 4'h7, 1, 2'd2, 0, 0, 0, 0, 0, 0);
        tbl[21] = mk(1, 4'h7, 0, 2'd0, 0, 1, 0, 0, 0, 1);
        tbl[22] = mk(1, 4'h7, 0, 2'd1, 0, 1, 0, 0, 0, 1);
        tbl[23] = mk(1, 4'h7, 0, 2'd2, 0, 1, 1, 0, 0, 1);
        tbl[24] = mk(1, 4'h7, 0, 2'd3, 1, 0, 0, 1, 0, 1);
        tbl[25] = mk(0, 4'h0, 0, 2'd0, 0, 0, 0, 0, 0, 1);
        tbl[26] = mk(0, 4'h0, 0, 2'd1, 0, 0, 0, 0, 0, 1);
        tbl[27] = mk(0, 4'h0, 0, 2'd2, 0, 0, 0, 1, 0, 1);
        tbl[28] = mk(0, 4'h0, 0, 2'd3, 1, 0, 0, 1, 0, 1);
        tbl[29] = mk(1, 4'h9, 0, 2'd3, 0, 0, 0, 1, 0, 1);
        tbl[30] = mk(0, 4'h0, 0, 2'd0, 0, 0, 0, 0, 0, 1);
        tbl[31] = mk(0, 4'h0, 0, 2'd1, 0, 0, 0, 0, 0, 1);
        tbl[32] = mk(0, 4'h0, 1, 2'd2, 0, 0, 0, 0, 0, 1);
        tbl[33] = mk(0, 4'h0, 0, 2'd0, 0, 1, 0, 0, 0, 2);
        tbl[34] = mk(0, 4'h0, 0, 2'd1, 0, 1, 0, 0, 0, 2);
        tbl[35] = mk(0, 4'h0, 1, 2'd2, 0, 1, 1, 0, 0, 2);
        tbl[36] = mk(1, 4'h4, 0, 2'd3, 0, 0, 0, 0, 1, 2);
        tbl[37] = mk(1, 4'h4, 1, 2'd3, 0, 0, 0, 0, 1, 2);
        tbl[38] = mk(1, 4'h4, 0, 2'd3, 0, 0, 0, 0, 1, 2);

        // Reset: pi_rdy must stay low even with a word offered.
        rst = 1'b1; pi_valid = 1'b1; pi = 4'hF; fail = 1'b0;
        @(negedge clk); #1;
        chk("reset pi_rdy", 32'(pi_rdy), 32'(0));
        @(negedge clk); #1;
        chk_idle_reset("reset");
        chk("reset pi_rdy 2", 32'(pi_rdy), 32'(0));
        pi_valid = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < NROWS; i++) begin
            r = tbl[i];
            cyc(r.v, r.p, r.f, 1'b0);
            chk($sformatf("row %0d ctl", i),
                32'({mc, save, rollBack, subst, pi_rdy, fatal}),
                32'({r.e_mc, r.e_sv, r.e_rb, r.e_sb, r.e_rdy, r.e_fat}));
            chk($sformatf("row %0d err_cnt", i), 32'(err_cnt), 32'(err_exp(r.e_err)));
            if (r.e_mc != 2'd3) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("row %0d queue underflow", i), 32'(1), 32'(0));
                end else begin
                    chk($sformatf("row %0d inNew", i), 32'(inNew), 32'(exp_q.pop_front()));
                end
            end
            if (r.v && r.e_rdy) begin
                last_word = r.p;
                repeat (3) exp_q.push_back(r.p);
            end
            if (r.f && (r.e_mc == 2'd2) && !r.e_rb) begin
                repeat (3) exp_q.push_back(last_word);
            end
        end
        chk("queue drained", 32'(exp_q.size()), 32'(0));

        // Fatal is sticky until reset, and reset clears it.
        cyc(1'b1, 4'h4, 1'b0, 1'b0);
        chk("fatal sticky", 32'({fatal, pi_rdy}), 32'({1'b1, 1'b0}));
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("fatal rst pi_rdy", 32'(pi_rdy), 32'(0));
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk_idle_reset("after fatal rst");

        // Reset in replay mc==1 drops the word with no save.
        cyc(1'b1, 4'h6, 1'b0, 1'b0);
        chk("rr accept", 32'(pi_rdy), 32'(1));
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("rr mc0", 32'({mc, inNew}), 32'({2'd0, 4'h6}));
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("rr replay mc0", 32'({mc, rollBack, err_cnt}), 32'({2'd0, 1'b1, err_exp(1)}));
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("rr replay mc1", 32'({mc, rollBack}), 32'({2'd1, 1'b1}));
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk_idle_reset("rr after rst");
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("rr no late save", 32'({mc, save}), 32'({2'd3, 1'b0}));

        // Five single faults: counter saturates at all-ones when built.
        for (int k = 1; k <= 5; k++) begin
            fault_word(WIDTH'(k + 8), k);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
